cond_branch_unit: RTL and testbench

- Consumes the ALU status flags (Negative, Zero, Overflow, CarryOut) from the EX stage.
- Holds the architectural NZCV flag register.
- Resolves B, B.cond, CBZ and CBNZ, then hands a registered redirect to fetch through a valid/ready handshake.
- Sits between the EX stage and the PC-select logic of the 5-stage pipeline.

---
 rtl/cond_branch_unit.sv | 114 +++++++++++
 tb/tb_cond_branch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cond_branch_unit.sv
// Conditional branch resolution unit: holds NZCV, resolves B/B.cond/CBZ/CBNZ
// and offers a registered redirect to fetch over a valid/ready handshake.
module cond_branch_unit #(
  parameter int AW   = 64,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_setflags,
  input  logic            Negative,
  input  logic            Zero,
  input  logic            Overflow,
  input  logic            CarryOut,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [1:0]      br_type,
  input  logic [3:0]      br_cond,
  input  logic [AW-1:0]   br_opnd,
  input  logic [AW-1:0]   br_pc,
  input  logic [AW-1:0]   br_target,
  input  logic            flush,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic            rd_taken,
  output logic [AW-1:0]   rd_pc,
  output logic [3:0]      flags,
  output logic [CNTW-1:0] taken_cnt
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_HOLD = 1'b1;

  localparam logic [1:0] T_B     = 2'b00;
  localparam logic [1:0] T_BCOND = 2'b01;
  localparam logic [1:0] T_CBZ   = 2'b10;

  logic       state;
  logic       set_now;
  logic [3:0] eff;
  logic       taken;
  logic       accept;

  // Condition codes pair up: odd encodings invert the even one, except 111x (always).
  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c[3:1])
      3'd0:    r = z;
      3'd1:    r = cy;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = cy & ~z;
      3'd5:    r = (n == v);
      3'd6:    r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    if (c[0] && (c[3:1] != 3'd7)) r = ~r;
    return r;
  endfunction

  assign set_now  = ex_valid & ex_setflags;
  assign eff      = set_now ? {Negative, Zero, CarryOut, Overflow} : flags;
  assign br_ready = (state == S_IDLE);
  assign rd_valid = (state == S_HOLD);
  assign accept   = br_valid & br_ready & ~flush;

  always_comb begin
    taken = 1'b0;
    case (br_type)
      T_B:     taken = 1'b1;
      T_BCOND: taken = cond_true(br_cond, eff);
      T_CBZ:   taken = (br_opnd == '0);
      default: taken = (br_opnd != '0);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       flags <= 4'b0000;
    else if (set_now) flags <= {Negative, Zero, CarryOut, Overflow};
  end

  // Flush wins over the handshake, so a flushed redirect is never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rd_taken  <= 1'b0;
      rd_pc     <= '0;
      taken_cnt <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_HOLD;
            rd_taken <= taken;
            rd_pc    <= taken ? br_target : br_pc + AW'(4);
          end
        end
        default: begin
          if (rd_ready) begin
            state     <= S_IDLE;
            taken_cnt <= taken_cnt + CNTW'(rd_taken);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cond_branch_unit.sv
// Directed self-checking bench for cond_branch_unit: flag bypass/latch,
// condition codes, CBZ/CBNZ, backpressure, flush, async reset and PC wrap.
module tb_cond_branch_unit;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, ex_setflags;
  logic        Negative, Zero, Overflow, CarryOut;
  logic        br_valid, br_ready;
  logic [1:0]  br_type;
  logic [3:0]  br_cond;
  logic [63:0] br_opnd, br_pc, br_target;
  logic        flush;
  logic        rd_valid, rd_ready, rd_taken;
  logic [63:0] rd_pc;
  logic [3:0]  flags;
  logic [31:0] taken_cnt;

  int assertCount = 0;
  int failCount   = 0;

  cond_branch_unit #(.AW(64), .CNTW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_setflags(ex_setflags),
    .Negative(Negative), .Zero(Zero), .Overflow(Overflow), .CarryOut(CarryOut),
    .br_valid(br_valid), .br_ready(br_ready), .br_type(br_type), .br_cond(br_cond),
    .br_opnd(br_opnd), .br_pc(br_pc), .br_target(br_target),
    .flush(flush),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_taken(rd_taken), .rd_pc(rd_pc),
    .flags(flags), .taken_cnt(taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] t, input logic [3:0] c,
                               input logic [63:0] opnd, input logic [63:0] pc,
                               input logic [63:0] tgt);
    br_type   = t;
    br_cond   = c;
    br_opnd   = opnd;
    br_pc     = pc;
    br_target = tgt;
    br_valid  = 1'b1;
  endtask

  task automatic setAlu(input logic v, input logic n, input logic z,
                        input logic cy, input logic ov);
    ex_valid    = v;
    ex_setflags = v;
    Negative    = n;
    Zero        = z;
    CarryOut    = cy;
    Overflow    = ov;
  endtask

  // Issue one branch, check the registered redirect, then complete the handshake.
  task automatic branchAndCheck(input string tag, input logic [1:0] t,
                                input logic [3:0] c, input logic [63:0] opnd,
                                input logic [63:0] pc, input logic [63:0] tgt,
                                input logic expTaken, input logic [63:0] expPc,
                                input logic [31:0] expCnt);
    rd_ready = 1'b1;
    applyStimulus(t, c, opnd, pc, tgt);
    step();
    br_valid = 1'b0;
    checkOutput({tag, "_valid"}, 64'(rd_valid), 64'd1);
    checkOutput({tag, "_taken"}, 64'(rd_taken), 64'(expTaken));
    checkOutput({tag, "_pc"}, rd_pc, expPc);
    step();
    checkOutput({tag, "_cnt"}, 64'(taken_cnt), 64'(expCnt));
  endtask

  initial begin
    rst_n = 1'b0;
    setAlu(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    br_valid = 1'b0; br_type = 2'b00; br_cond = 4'h0;
    br_opnd = '0; br_pc = '0; br_target = '0;
    flush = 1'b0; rd_ready = 1'b0;

    #12;
    checkOutput("rst_rd_valid", 64'(rd_valid), 64'd0);
    checkOutput("rst_br_ready", 64'(br_ready), 64'd1);
    checkOutput("rst_flags", 64'(flags), 64'd0);
    checkOutput("rst_cnt", 64'(taken_cnt), 64'd0);
    checkOutput("rst_rd_pc", rd_pc, 64'd0);
    checkOutput("rst_rd_taken", 64'(rd_taken), 64'd0);
    rst_n = 1'b1;
    step();

    // ADDS 0x7FFF..FF + 1 -> N=1 Z=0 C=0 V=1, bypassed into B.cond LT
    setAlu(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    rd_ready = 1'b0;
    applyStimulus(2'b01, 4'b1011, 64'd0, 64'h1000, 64'h2000);
    step();
    br_valid = 1'b0;
    setAlu(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lt_bypass_taken", 64'(rd_taken), 64'd0);
    checkOutput("lt_bypass_pc", rd_pc, 64'h1004);
    checkOutput("lt_flags", 64'(flags), 64'b1001);
    checkOutput("lt_br_ready", 64'(br_ready), 64'd0);
    rd_ready = 1'b1;
    step();
    checkOutput("lt_done", 64'(rd_valid), 64'd0);
    branchAndCheck("vs", 2'b01, 4'b0110, 64'd0, 64'h1100, 64'h2000, 1'b1, 64'h2000, 32'd1);

    // SUBS 0-1 -> N=1 Z=0 C=0 V=0, latched then used from the register
    setAlu(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    setAlu(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("subs_flags", 64'(flags), 64'b1000);
    branchAndCheck("hi", 2'b01, 4'b1000, 64'd0, 64'h3000, 64'h4000, 1'b0, 64'h3004, 32'd1);
    branchAndCheck("ls", 2'b01, 4'b1001, 64'd0, 64'h3000, 64'h4000, 1'b1, 64'h4000, 32'd2);
    branchAndCheck("ge", 2'b01, 4'b1010, 64'd0, 64'h3000, 64'h4000, 1'b0, 64'h3004, 32'd2);
    branchAndCheck("gt", 2'b01, 4'b1100, 64'd0, 64'h3000, 64'h4000, 1'b0, 64'h3004, 32'd2);
    branchAndCheck("mi", 2'b01, 4'b0100, 64'd0, 64'h3000, 64'h4000, 1'b1, 64'h4000, 32'd3);
    branchAndCheck("al", 2'b01, 4'b1110, 64'd0, 64'h3000, 64'h4800, 1'b1, 64'h4800, 32'd4);

    branchAndCheck("cbz0", 2'b10, 4'h0, 64'd0, 64'h100, 64'h40, 1'b1, 64'h40, 32'd5);
    branchAndCheck("cbz5", 2'b10, 4'h0, 64'd5, 64'h100, 64'h40, 1'b0, 64'h104, 32'd5);
    branchAndCheck("cbnz5", 2'b11, 4'h0, 64'd5, 64'h100, 64'h40, 1'b1, 64'h40, 32'd6);

    // Backpressure: redirect must hold for three cycles without fetch accepting
    rd_ready = 1'b0;
    applyStimulus(2'b00, 4'h0, 64'd0, 64'h200, 64'h300);
    step();
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_valid", 64'(rd_valid), 64'd1);
      checkOutput("bp_pc", rd_pc, 64'h300);
      checkOutput("bp_br_ready", 64'(br_ready), 64'd0);
      step();
    end
    br_valid = 1'b0;
    rd_ready = 1'b1;
    step();
    checkOutput("bp_release", 64'(rd_valid), 64'd0);
    checkOutput("bp_cnt", 64'(taken_cnt), 64'd7);

    // Flush in HOLD beats the handshake
    rd_ready = 1'b0;
    applyStimulus(2'b00, 4'h0, 64'd0, 64'h500, 64'h600);
    step();
    br_valid = 1'b0;
    rd_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush_valid", 64'(rd_valid), 64'd0);
    checkOutput("flush_cnt", 64'(taken_cnt), 64'd7);
    checkOutput("flush_br_ready", 64'(br_ready), 64'd1);

    // Flush in IDLE drops the request but still lets flags update
    applyStimulus(2'b00, 4'h0, 64'd0, 64'h700, 64'h800);
    setAlu(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    br_valid = 1'b0;
    setAlu(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_flush_valid", 64'(rd_valid), 64'd0);
    checkOutput("idle_flush_flags", 64'(flags), 64'b1111);

    // Async reset while HOLD
    rd_ready = 1'b0;
    applyStimulus(2'b00, 4'h0, 64'd0, 64'h900, 64'hA00);
    step();
    br_valid = 1'b0;
    checkOutput("pre_rst_valid", 64'(rd_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(rd_valid), 64'd0);
    checkOutput("arst_flags", 64'(flags), 64'd0);
    checkOutput("arst_cnt", 64'(taken_cnt), 64'd0);
    checkOutput("arst_br_ready", 64'(br_ready), 64'd1);
    #1 rst_n = 1'b1;
    step();

    branchAndCheck("wrap", 2'b11, 4'h0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40,
                   1'b0, 64'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
